// File: rtl/csr_file_m.sv
// Machine-mode CSR file: mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval/counters.
// Ports: CSR access (i_csr_*/o_csr_*), trap/MRET control, irq lines, trap target PCs.
module csr_file_m #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] MTVEC_RST    = '0,
    parameter logic [XLEN-1:0] MEPC_RST     = XLEN'(64'h8000_0000),
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_csr_en,
    input  logic [2:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    input  logic [4:0]      i_csr_zimm,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_illegal,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_mret_valid,
    input  logic            i_instr_retire,
    input  logic            i_irq_sw,
    input  logic            i_irq_timer,
    input  logic            i_irq_ext,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_mepc_o,
    output logic            o_irq_pending
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mcycle;
    logic [XLEN-1:0] r_minstret;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_new;
    logic            w_impl;
    logic            w_f_range;
    logic            w_intent;
    logic            w_bad_op;
    logic            w_illegal;
    logic            w_we;
    logic [XLEN-1:0] w_base;

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mstatus_mpie;
        w_mstatus[3]     = r_mstatus_mie;
    end

    always_comb begin
        w_mip     = '0;
        w_mip[3]  = i_irq_sw;
        w_mip[7]  = i_irq_timer;
        w_mip[11] = i_irq_ext;
    end

    // Read mux; also flags which addresses exist at all.
    always_comb begin
        w_old     = '0;
        w_impl    = 1'b1;
        w_f_range = 1'b0;
        case (i_csr_addr)
            A_MSTATUS:  w_old = w_mstatus;
            A_MIE:      w_old = r_mie;
            A_MTVEC:    w_old = r_mtvec;
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = r_mepc;
            A_MCAUSE:   w_old = r_mcause;
            A_MTVAL:    w_old = r_mtval;
            A_MIP:      w_old = w_mip;
            A_MCYCLE:   w_old = r_mcycle;
            A_MINSTRET: w_old = r_minstret;
            12'hF11, 12'hF12, 12'hF13, 12'hF14:
                w_f_range = 1'b1;
            default:    w_impl = 1'b0;
        endcase
    end

    assign w_src = i_csr_op[2]
                 ? {{(XLEN-5){1'b0}}, i_csr_zimm}
                 : i_csr_wdata;

    // Set/clear forms with a zero rs1/uimm field are pure reads.
    assign w_intent = (i_csr_op[1:0] == 2'b01)
                    || (i_csr_zimm != 5'd0);

    always_comb begin
        w_new = w_old;
        case (i_csr_op[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    assign w_bad_op  = (i_csr_op[1:0] == 2'b00);
    assign w_illegal = i_csr_en
                     && (!w_impl || w_bad_op
                         || (w_f_range && w_intent));

    // Trap and MRET pre-empt the CSR write completely.
    assign w_we = i_csr_en && !w_illegal && w_intent
               && !i_trap_valid && !i_mret_valid;

    assign o_csr_illegal = w_illegal;
    assign o_csr_rdata   = (i_csr_en && !w_illegal) ? w_old : '0;

    assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        o_trap_vector = w_base;
        if (r_mtvec[0] && i_trap_cause[XLEN-1])
            o_trap_vector = w_base
                          + {{(XLEN-7){1'b0}},
                             i_trap_cause[4:0], 2'b00};
    end

    assign o_mepc_o      = r_mepc;
    assign o_irq_pending = r_mstatus_mie && |(w_mip & r_mie);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST & ~XLEN'(2);
            r_mscratch     <= '0;
            r_mepc         <= MEPC_RST & ~XLEN'(3);
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            if (HAS_COUNTERS) begin
                if (w_we && i_csr_addr == A_MCYCLE)
                    r_mcycle <= w_new;
                else
                    r_mcycle <= r_mcycle + 1'b1;
                if (w_we && i_csr_addr == A_MINSTRET)
                    r_minstret <= w_new;
                else
                    r_minstret <= r_minstret
                                + XLEN'(i_instr_retire);
            end
            if (i_trap_valid) begin
                r_mepc         <= i_trap_pc & ~XLEN'(3);
                r_mcause       <= i_trap_cause;
                r_mtval        <= i_trap_tval;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (i_mret_valid) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_we) begin
                case (i_csr_addr)
                    A_MSTATUS: begin
                        r_mstatus_mie  <= w_new[3];
                        r_mstatus_mpie <= w_new[7];
                    end
                    A_MIE:      r_mie      <= w_new & IRQ_MASK;
                    A_MTVEC:    r_mtvec    <= w_new & ~XLEN'(2);
                    A_MSCRATCH: r_mscratch <= w_new;
                    A_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
                    A_MCAUSE:   r_mcause   <= w_new;
                    A_MTVAL:    r_mtval    <= w_new;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_file_m.sv
// Directed scoreboard bench for csr_file_m.
// Stimulus queues expectations; a negedge monitor compares them.
module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [2:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [4:0]  csr_zimm = '0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_tval = '0;
    logic        mret_valid = 1'b0;
    logic        instr_retire = 1'b0;
    logic        irq_sw = 1'b0;
    logic        irq_timer = 1'b0;
    logic        irq_ext = 1'b0;
    logic [63:0] trap_vector;
    logic [63:0] mepc_o;
    logic        irq_pending;

    csr_file_m dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_csr_en       (csr_en),
        .i_csr_op       (csr_op),
        .i_csr_addr     (csr_addr),
        .i_csr_wdata    (csr_wdata),
        .i_csr_zimm     (csr_zimm),
        .o_csr_rdata    (csr_rdata),
        .o_csr_illegal  (csr_illegal),
        .i_trap_valid   (trap_valid),
        .i_trap_pc      (trap_pc),
        .i_trap_cause   (trap_cause),
        .i_trap_tval    (trap_tval),
        .i_mret_valid   (mret_valid),
        .i_instr_retire (instr_retire),
        .i_irq_sw       (irq_sw),
        .i_irq_timer    (irq_timer),
        .i_irq_ext      (irq_ext),
        .o_trap_vector  (trap_vector),
        .o_mepc_o       (mepc_o),
        .o_irq_pending  (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int S_RD   = 0;
    localparam int S_ILL  = 1;
    localparam int S_TVEC = 2;
    localparam int S_MEPC = 3;
    localparam int S_IRQ  = 4;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.sel)
                S_RD:    act = csr_rdata;
                S_ILL:   act = {63'd0, csr_illegal};
                S_TVEC:  act = trap_vector;
                S_MEPC:  act = mepc_o;
                default: act = {63'd0, irq_pending};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h",
                         e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string nm, input int sel,
                            input logic [63:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [2:0] op,
                       input logic [11:0] addr,
                       input logic [63:0] wd,
                       input logic [4:0] zimm,
                       input logic [63:0] exp_rd,
                       input logic exp_ill,
                       input bit chk_rd,
                       input string nm);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        csr_zimm  = zimm;
        if (chk_rd)
            expect_v({nm, "_rdata"}, S_RD, exp_rd);
        expect_v({nm, "_illegal"}, S_ILL, {63'd0, exp_ill});
        step();
        csr_en    = 1'b0;
        csr_op    = '0;
        csr_wdata = '0;
        csr_zimm  = '0;
    endtask

    task automatic rd(input logic [11:0] addr,
                      input logic [63:0] exp_rd,
                      input string nm);
        csr(3'b010, addr, 64'd0, 5'd0, exp_rd, 1'b0, 1'b1, nm);
    endtask

    initial begin
        step();
        // reset state
        expect_v("rst_irq", S_IRQ, 64'd0);
        rd(12'h300, 64'h1800, "rst_mstatus");
        expect_v("rst_mepc_o", S_MEPC, 64'h8000_0000);
        rd(12'h341, 64'h8000_0000, "rst_mepc");
        rd(12'h305, 64'h0, "rst_mtvec");
        rst_n = 1'b1;
        step();

        // mtvec and vectored trap target
        csr(3'b001, 12'h305, 64'h8000_0101, 5'd1,
            64'd0, 1'b0, 1'b1, "mtvec_wr");
        expect_v("tvec_direct", S_TVEC, 64'h8000_0100);
        rd(12'h305, 64'h8000_0101, "mtvec_rd");
        trap_valid = 1'b1;
        trap_pc    = 64'h8000_2000;
        trap_cause = 64'h8000_0000_0000_0007;
        expect_v("tvec_vectored", S_TVEC, 64'h8000_011C);
        step();
        trap_valid = 1'b0;
        trap_cause = '0;
        rd(12'h341, 64'h8000_2000, "trap1_mepc");
        rd(12'h342, 64'h8000_0000_0000_0007, "trap1_mcause");

        // enable timer interrupt
        csr(3'b010, 12'h300, 64'h8, 5'd1,
            64'h1800, 1'b0, 1'b1, "mstatus_set");
        csr(3'b010, 12'h304, 64'h80, 5'd1,
            64'h0, 1'b0, 1'b1, "mie_set");
        irq_timer = 1'b1;
        expect_v("irq_on", S_IRQ, 64'd1);
        rd(12'h304, 64'h80, "mie_rd");
        rd(12'h300, 64'h1808, "mstatus_rd");

        // trap collides with CSR write
        trap_valid = 1'b1;
        trap_pc    = 64'h8000_1002;
        trap_cause = 64'd2;
        trap_tval  = 64'hDEAD;
        expect_v("irq_pre_trap", S_IRQ, 64'd1);
        csr(3'b001, 12'h340, 64'h1234, 5'd1,
            64'd0, 1'b0, 1'b1, "trap_vs_wr");
        trap_valid = 1'b0;
        trap_cause = '0;
        rd(12'h340, 64'd0, "dropped_wr");
        expect_v("trap_mepc_o", S_MEPC, 64'h8000_1000);
        rd(12'h341, 64'h8000_1000, "trap_mepc");
        rd(12'h342, 64'd2, "trap_mcause");
        rd(12'h343, 64'hDEAD, "trap_mtval");
        expect_v("irq_masked", S_IRQ, 64'd0);
        rd(12'h300, 64'h1880, "trap_mstatus");

        // MRET beats CSR write
        mret_valid = 1'b1;
        csr(3'b001, 12'h340, 64'h55, 5'd1,
            64'd0, 1'b0, 1'b1, "mret_vs_wr");
        mret_valid = 1'b0;
        expect_v("irq_after_mret", S_IRQ, 64'd1);
        rd(12'h300, 64'h1888, "mret_mstatus");
        rd(12'h340, 64'd0, "mret_drop");

        // mip is read-only and masked
        csr(3'b011, 12'h344, 64'h80, 5'd1,
            64'h80, 1'b0, 1'b1, "mip_clr");
        rd(12'h344, 64'h80, "mip_keep");
        irq_timer = 1'b0;
        irq_sw    = 1'b1;
        irq_ext   = 1'b1;
        expect_v("irq_mie_mask", S_IRQ, 64'd0);
        rd(12'h344, 64'h808, "mip_lines");
        irq_sw  = 1'b0;
        irq_ext = 1'b0;

        // legality
        csr(3'b010, 12'hF11, 64'h0, 5'd0,
            64'd0, 1'b0, 1'b1, "f11_rs0");
        csr(3'b001, 12'hF11, 64'h5, 5'd1,
            64'd0, 1'b1, 1'b1, "f11_rw");
        csr(3'b010, 12'h7C0, 64'h0, 5'd0,
            64'd0, 1'b1, 1'b1, "unimpl");
        csr(3'b001, 12'h7C0, 64'h7, 5'd1,
            64'd0, 1'b1, 1'b1, "unimpl_rw");
        csr(3'b000, 12'h300, 64'h0, 5'd1,
            64'd0, 1'b1, 1'b1, "op000");
        csr(3'b100, 12'h340, 64'h99, 5'd1,
            64'd0, 1'b1, 1'b1, "op100");
        rd(12'h340, 64'd0, "ill_nochg");
        rd(12'h300, 64'h1888, "ill_mstatus");

        // immediate forms and zero-source no-write
        csr(3'b101, 12'h340, 64'hFFFF, 5'h1F,
            64'd0, 1'b0, 1'b1, "rwi");
        rd(12'h340, 64'h1F, "rwi_rd");
        csr(3'b111, 12'h340, 64'h0, 5'h3,
            64'h1F, 1'b0, 1'b1, "rci");
        rd(12'h340, 64'h1C, "rci_rd");
        csr(3'b110, 12'h340, 64'hFF, 5'h0,
            64'h1C, 1'b0, 1'b1, "rsi0");
        csr(3'b010, 12'h340, 64'hFF00, 5'h0,
            64'h1C, 1'b0, 1'b1, "rs_x0");
        rd(12'h340, 64'h1C, "nowr_rd");

        // field masks
        csr(3'b001, 12'h300, 64'h0, 5'd1,
            64'h1888, 1'b0, 1'b1, "mstatus_clr");
        rd(12'h300, 64'h1800, "mpp_fixed");
        csr(3'b001, 12'h341, 64'h1237, 5'd1,
            64'h8000_1000, 1'b0, 1'b1, "mepc_wr");
        rd(12'h341, 64'h1234, "mepc_align");
        csr(3'b001, 12'h305, 64'h7, 5'd1,
            64'h8000_0101, 1'b0, 1'b1, "mtvec_wr2");
        rd(12'h305, 64'h5, "mtvec_bit1");
        csr(3'b001, 12'h304, 64'hFFFF, 5'd1,
            64'h80, 1'b0, 1'b1, "mie_wr");
        rd(12'h304, 64'h888, "mie_mask");

        // mcycle wrap
        csr(3'b001, 12'hB00, '1, 5'd1,
            64'd0, 1'b0, 1'b0, "mcycle_wr");
        rd(12'hB00, '1, "mcycle_max");
        rd(12'hB00, 64'd0, "mcycle_wrap");
        rd(12'hB00, 64'd1, "mcycle_inc");

        // minstret
        csr(3'b001, 12'hB02, 64'd0, 5'd1,
            64'd0, 1'b0, 1'b1, "minstret_wr");
        instr_retire = 1'b1;
        step();
        instr_retire = 1'b0;
        step();
        instr_retire = 1'b1;
        step();
        step();
        instr_retire = 1'b0;
        rd(12'hB02, 64'd3, "minstret_3");
        instr_retire = 1'b1;
        rd(12'hB02, 64'd3, "minstret_old");
        instr_retire = 1'b0;
        rd(12'hB02, 64'd4, "minstret_4");

        // async reset mid-count
        rst_n = 1'b0;
        expect_v("arst_mepc_o", S_MEPC, 64'h8000_0000);
        rd(12'hB00, 64'd0, "arst_mcycle");
        rd(12'h305, 64'd0, "arst_mtvec");
        rst_n = 1'b1;
        rd(12'hB00, 64'd0, "rel_mcycle0");
        rd(12'hB00, 64'd1, "rel_mcycle1");

        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
